// File: rtl/ext_gpio_bridge.sv
// EXT-bus GPIO slave: synchronised and debounced inputs, sticky rising-edge
// capture (W1C), level interrupt and a byte-writable output register.
// Pipelined address/data timing: read data is registered at the address phase.
module ext_gpio_bridge #(
    parameter int unsigned IN_WIDTH         = 4,
    parameter int unsigned OUT_WIDTH        = 4,
    parameter int unsigned AWIDTH           = 16,
    parameter int unsigned SAMPLE_COUNT_MAX = 25000,
    parameter int unsigned PULSE_COUNT_MAX  = 200,
    parameter logic [31:0] ID_VALUE         = 32'h6770_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EXT_HSEL,
    input  logic                 EXT_HWRITE,
    input  logic [AWIDTH-1:0]    EXT_HADDR,
    input  logic [2:0]           EXT_HSIZE,
    input  logic [31:0]          EXT_HWDATA,
    output logic [31:0]          EXT_HRDATA,
    output logic                 EXT_HREADYOUT,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);

    localparam int unsigned SW = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
    localparam int unsigned PW = $clog2(PULSE_COUNT_MAX + 1);

    localparam logic [3:0] IdxRaw  = 4'd0;
    localparam logic [3:0] IdxDeb  = 4'd1;
    localparam logic [3:0] IdxEdge = 4'd2;
    localparam logic [3:0] IdxOut  = 4'd3;
    localparam logic [3:0] IdxIrqEn = 4'd4;
    localparam logic [3:0] IdxId   = 4'd5;

    // Bus pipeline state
    logic                 sel_q, wr_q;
    logic [3:0]           idx_q, be_q;
    logic [31:0]          rdata_q;
    // GPIO state
    logic [IN_WIDTH-1:0]  sync1_q, raw_q, deb_q, deb_d, deb_prev_q;
    logic [IN_WIDTH-1:0]  edge_q, edge_d, irq_en_q, irq_en_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [IN_WIDTH-1:0][PW-1:0] pcnt_q, pcnt_d;

    logic        tick, wr_en;
    logic [3:0]  be_a;
    logic [31:0] bmask, rd_mux;

    // Only HADDR[5:0] is decoded; the rest is deliberately ignored
    logic unused_haddr;
    assign unused_haddr = ^EXT_HADDR[AWIDTH-1:6];

    assign EXT_HREADYOUT = sel_q;
    assign EXT_HRDATA    = rdata_q;
    assign gpio_out      = out_q;
    assign irq           = |(edge_q & irq_en_q);

    assign tick  = (scnt_q == SW'(SAMPLE_COUNT_MAX - 1));
    assign wr_en = sel_q & wr_q;
    assign bmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    // Byte enables for the address phase; misaligned or unknown sizes write nothing
    always_comb begin
        be_a = 4'b0000;
        case (EXT_HSIZE)
            3'd0: be_a = 4'b0001 << EXT_HADDR[1:0];
            3'd1: begin
                if (EXT_HADDR[1:0] == 2'd0)      be_a = 4'b0011;
                else if (EXT_HADDR[1:0] == 2'd2) be_a = 4'b1100;
            end
            3'd2: if (EXT_HADDR[1:0] == 2'd0) be_a = 4'b1111;
            default: be_a = 4'b0000;
        endcase
    end

    // Data-phase writes, W1C edge clear (set wins) and debounce next state
    always_comb begin
        logic [31:0] out_ext, en_ext, edge_clr32;
        out_ext = '0;
        en_ext  = '0;
        out_ext[OUT_WIDTH-1:0] = out_q;
        en_ext[IN_WIDTH-1:0]   = irq_en_q;
        out_ext    = (out_ext & ~bmask) | (EXT_HWDATA & bmask);
        en_ext     = (en_ext & ~bmask) | (EXT_HWDATA & bmask);
        edge_clr32 = (wr_en && idx_q == IdxEdge) ? (EXT_HWDATA & bmask) : 32'd0;

        out_d    = (wr_en && idx_q == IdxOut) ? out_ext[OUT_WIDTH-1:0] : out_q;
        irq_en_d = (wr_en && idx_q == IdxIrqEn) ? en_ext[IN_WIDTH-1:0] : irq_en_q;
        edge_d   = (edge_q & ~edge_clr32[IN_WIDTH-1:0]) | (deb_q & ~deb_prev_q);

        scnt_d = tick ? '0 : scnt_q + SW'(1);
        deb_d  = deb_q;
        pcnt_d = pcnt_q;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (tick) begin
                if (raw_q[i] != deb_q[i]) begin
                    if (pcnt_q[i] == PW'(PULSE_COUNT_MAX - 1)) begin
                        deb_d[i]  = raw_q[i];
                        pcnt_d[i] = '0;
                    end else begin
                        pcnt_d[i] = pcnt_q[i] + PW'(1);
                    end
                end else begin
                    pcnt_d[i] = '0;
                end
            end
        end
    end

    // Read mux; RW registers forward the concurrent data-phase write so a
    // back-to-back write/read returns the new value. EDGE reads pre-clear.
    always_comb begin
        rd_mux = '0;
        case (EXT_HADDR[5:2])
            IdxRaw:   rd_mux[IN_WIDTH-1:0]  = raw_q;
            IdxDeb:   rd_mux[IN_WIDTH-1:0]  = deb_q;
            IdxEdge:  rd_mux[IN_WIDTH-1:0]  = edge_q;
            IdxOut:   rd_mux[OUT_WIDTH-1:0] = out_d;
            IdxIrqEn: rd_mux[IN_WIDTH-1:0]  = irq_en_d;
            IdxId:    rd_mux                = ID_VALUE;
            default:  rd_mux                = '0;
        endcase
    end

    // All state, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= 1'b0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            sync1_q    <= '0;
            raw_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            edge_q     <= '0;
            irq_en_q   <= '0;
            out_q      <= '0;
            scnt_q     <= '0;
            pcnt_q     <= '0;
        end else begin
            sel_q <= EXT_HSEL;
            if (EXT_HSEL) begin
                wr_q  <= EXT_HWRITE;
                idx_q <= EXT_HADDR[5:2];
                be_q  <= be_a;
            end
            rdata_q    <= (EXT_HSEL && !EXT_HWRITE) ? rd_mux : 32'd0;
            sync1_q    <= gpio_in;
            raw_q      <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            edge_q     <= edge_d;
            irq_en_q   <= irq_en_d;
            out_q      <= out_d;
            scnt_q     <= scnt_d;
            pcnt_q     <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_ext_gpio_bridge.sv
// Directed bench for ext_gpio_bridge: table of single transactions plus
// hand-written sequences for debounce, edge/irq, W1C race and mid-transfer reset.
module tb_ext_gpio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXT_HSEL, EXT_HWRITE;
    logic [15:0] EXT_HADDR;
    logic [2:0]  EXT_HSIZE;
    logic [31:0] EXT_HWDATA, EXT_HRDATA;
    logic        EXT_HREADYOUT;
    logic [3:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    ext_gpio_bridge #(
        .IN_WIDTH(4), .OUT_WIDTH(8), .AWIDTH(16),
        .SAMPLE_COUNT_MAX(4), .PULSE_COUNT_MAX(3), .ID_VALUE(32'h6770_0001)
    ) dut (
        .clk(clk), .rst(rst),
        .EXT_HSEL(EXT_HSEL), .EXT_HWRITE(EXT_HWRITE), .EXT_HADDR(EXT_HADDR),
        .EXT_HSIZE(EXT_HSIZE), .EXT_HWDATA(EXT_HWDATA), .EXT_HRDATA(EXT_HRDATA),
        .EXT_HREADYOUT(EXT_HREADYOUT),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction: address phase, then data phase where read data is sampled
    task automatic bus_xfer(input bit wr, input logic [15:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, output logic [31:0] rd,
                            output logic rdy);
        @(negedge clk);
        EXT_HSEL = 1'b1; EXT_HWRITE = wr; EXT_HADDR = addr; EXT_HSIZE = size;
        EXT_HWDATA = 32'd0;
        @(negedge clk);
        EXT_HSEL = 1'b0; EXT_HWDATA = wdata;
        rd = EXT_HRDATA; rdy = EXT_HREADYOUT;
        @(negedge clk);
        EXT_HWDATA = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t        vecs[15];
    logic [31:0] rd;
    logic        rdy;
    bit          found;

    initial begin
        rst = 1'b1; EXT_HSEL = 1'b0; EXT_HWRITE = 1'b0; EXT_HADDR = '0;
        EXT_HSIZE = 3'd2; EXT_HWDATA = '0; gpio_in = '0;

        vecs[0]  = '{1'b0, 16'h0014, 3'd2, 32'h0,        32'h6770_0001, 8'h00};
        vecs[1]  = '{1'b0, 16'h003C, 3'd2, 32'h0,        32'h0,         8'h00};
        vecs[2]  = '{1'b1, 16'h000C, 3'd2, 32'h0000_00A5, 32'h0,        8'hA5};
        vecs[3]  = '{1'b0, 16'h000C, 3'd2, 32'h0,        32'h0000_00A5, 8'hA5};
        vecs[4]  = '{1'b1, 16'h000C, 3'd0, 32'h0000_003C, 32'h0,        8'h3C};
        vecs[5]  = '{1'b1, 16'h000E, 3'd1, 32'hFFFF_0000, 32'h0,        8'h3C};
        vecs[6]  = '{1'b1, 16'h000D, 3'd0, 32'h0000_FF00, 32'h0,        8'h3C};
        vecs[7]  = '{1'b1, 16'h000E, 3'd2, 32'hFFFF_FFFF, 32'h0,        8'h3C};
        vecs[8]  = '{1'b1, 16'h000C, 3'd3, 32'h0000_0011, 32'h0,        8'h3C};
        vecs[9]  = '{1'b1, 16'h0010, 3'd2, 32'hFFFF_FFFF, 32'h0,        8'h3C};
        vecs[10] = '{1'b0, 16'h0010, 3'd2, 32'h0,        32'h0000_000F, 8'h3C};
        vecs[11] = '{1'b1, 16'h0014, 3'd2, 32'h1234_5678, 32'h0,        8'h3C};
        vecs[12] = '{1'b0, 16'h0014, 3'd2, 32'h0,        32'h6770_0001, 8'h3C};
        vecs[13] = '{1'b1, 16'h0000, 3'd2, 32'h0000_000F, 32'h0,        8'h3C};
        vecs[14] = '{1'b0, 16'h0000, 3'd2, 32'h0,        32'h0,         8'h3C};

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_hreadyout", {31'd0, EXT_HREADYOUT}, 32'd0);
        check("rst_hrdata", EXT_HRDATA, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            bus_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rdy);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_ready", i), {31'd0, rdy}, 32'd1);
            check($sformatf("vec%0d_out", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_out});
        end

        // Back-to-back: write OUT then read OUT on the very next cycle
        @(negedge clk);
        EXT_HSEL = 1'b1; EXT_HWRITE = 1'b1; EXT_HADDR = 16'h000C; EXT_HSIZE = 3'd2;
        @(negedge clk);
        EXT_HWDATA = 32'h0000_005A; EXT_HWRITE = 1'b0;
        @(negedge clk);
        EXT_HSEL = 1'b0; EXT_HWDATA = 32'd0;
        check("b2b_read", EXT_HRDATA, 32'h0000_005A);
        check("b2b_out", {24'd0, gpio_out}, 32'h0000_005A);
        @(negedge clk);
        check("idle_hrdata", EXT_HRDATA, 32'd0);
        check("idle_ready", {31'd0, EXT_HREADYOUT}, 32'd0);

        // Debounce of channel 0
        do_reset();
        gpio_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        bus_xfer(1'b0, 16'h0000, 3'd2, 32'd0, rd, rdy);
        check("raw0_sync", rd, 32'h1);
        bus_xfer(1'b0, 16'h0004, 3'd2, 32'd0, rd, rdy);
        check("deb0_early", rd, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            bus_xfer(1'b0, 16'h0004, 3'd2, 32'd0, rd, rdy);
            if (rd[0]) found = 1'b1;
        end
        check("deb0_rise", {31'd0, found}, 32'd1);
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("edge0_set", rd, 32'h1);

        // Glitches on channel 1 each spanning at most two ticks
        for (int g = 0; g < 3; g++) begin
            gpio_in[1] = 1'b1;
            repeat (6) @(negedge clk);
            gpio_in[1] = 1'b0;
            repeat (12) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        bus_xfer(1'b0, 16'h0004, 3'd2, 32'd0, rd, rdy);
        check("glitch_deb", rd, 32'h1);
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("glitch_edge", rd, 32'h1);

        // Interrupt gating and W1C
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus_xfer(1'b1, 16'h0010, 3'd2, 32'h1, rd, rdy);
        check("irq_on", {31'd0, irq}, 32'd1);
        bus_xfer(1'b1, 16'h0008, 3'd2, 32'h1, rd, rdy);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("edge0_cleared", rd, 32'h0);

        // Falling edge does not set EDGE
        gpio_in[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            bus_xfer(1'b0, 16'h0004, 3'd2, 32'd0, rd, rdy);
            if (!rd[0]) found = 1'b1;
        end
        check("deb0_fall", {31'd0, found}, 32'd1);
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("edge_no_fall", rd, 32'h0);

        // W1C lands in the same cycle as a new rising-edge set: set wins
        gpio_in[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (dut.tick && dut.pcnt_q[0] == 2'd2 && dut.raw_q[0]) found = 1'b1;
        end
        check("race_align", {31'd0, found}, 32'd1);
        EXT_HSEL = 1'b1; EXT_HWRITE = 1'b1; EXT_HADDR = 16'h0008; EXT_HSIZE = 3'd2;
        @(negedge clk);
        EXT_HSEL = 1'b0; EXT_HWDATA = 32'h1;
        @(negedge clk);
        EXT_HWDATA = 32'd0;
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("race_edge", rd, 32'h1);
        check("race_irq", {31'd0, irq}, 32'd1);

        // Reset between address and data phase drops the write
        bus_xfer(1'b1, 16'h000C, 3'd2, 32'h77, rd, rdy);
        check("pre_rst_out", {24'd0, gpio_out}, 32'h77);
        @(negedge clk);
        EXT_HSEL = 1'b1; EXT_HWRITE = 1'b1; EXT_HADDR = 16'h000C; EXT_HSIZE = 3'd2;
        @(negedge clk);
        EXT_HSEL = 1'b0; EXT_HWDATA = 32'hFF; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; EXT_HWDATA = 32'd0;
        check("mid_rst_out", {24'd0, gpio_out}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_ready", {31'd0, EXT_HREADYOUT}, 32'd0);
        check("mid_rst_rdata", EXT_HRDATA, 32'd0);
        bus_xfer(1'b0, 16'h000C, 3'd2, 32'd0, rd, rdy);
        check("mid_rst_out_rd", rd, 32'd0);
        bus_xfer(1'b0, 16'h0004, 3'd2, 32'd0, rd, rdy);
        check("mid_rst_deb", rd, 32'd0);
        bus_xfer(1'b0, 16'h0008, 3'd2, 32'd0, rd, rdy);
        check("mid_rst_edge", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
